dt_scan_seq: RTL and testbench
==============================

Name: dt_scan_seq

Overview:
- Pass sequencer for the distance-transform datapath. Walks the interior pixels of the result memory in raster order (forward pass) or reverse raster order (backward pass).
- For each pixel it issues the centre and four neighbour reads, computes the chamfer minimum and writes the result back.
- Sits between the top-level pass controller, which gives start/dir and takes done, and the single-port res memory.

Parameters:
- W, 128, image width in pixels; must be a power of two.
- H, 128, image height in pixels.
- DW, 8, pixel/distance data width.
- AW, 14, res memory address width; equals log2(W*H).

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low
- start  in  1  one-cycle pass request; sampled only in IDLE
- dir  in  1  pass direction: 0 forward, 1 backward; latched with start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse, pass complete
- res_addr  out  AW  res memory address
- res_rd  out  1  read strobe; res_di valid the following cycle
- res_wr  out  1  write strobe
- res_do  out  DW  write data
- res_di  in  DW  read data, one-cycle latency after res_rd

Behaviour:
- Reset (reset=0 at clk edge):
  - state goes to IDLE.
  - busy, done, res_rd, res_wr = 0; res_addr = 0; res_do = 0.
  - All internal registers are cleared.
  - Reset mid-pass aborts the pass immediately; no write is issued in the reset cycle.
- Scan range:
  - rows 1..H-2, cols 1..W-2. Border pixels are never read or written.
  - address = {row, col}, i.e. row*W + col.
  - Forward starts at (1,1): col increments, wrapping to col 1 with row+1.
  - Backward starts at (H-2,W-2): col decrements, wrapping to col W-2 with row-1.
- Neighbour offsets:
  - Forward, in order NW, N, NE, W: -W-1, -W, -W+1, -1.
  - Backward, in order E, SW, S, SE: +1, +W-1, +W, +W+1.
- States: IDLE, RDC, CHK, RDN, LAST, WR, FIN.
  - IDLE: start=1 latches dir, loads the start pixel, goes to RDC. start while busy is ignored.
  - RDC: res_rd=1, res_addr = centre. Goes to CHK.
  - CHK: captures centre from res_di.
    - Centre == 0: the pixel is skipped with no writes. Advance to the next pixel and go to RDC, or to FIN if this was the last pixel.
    - Centre != 0: set k=0, go to RDN.
  - RDN: res_rd=1, res_addr = centre + offset[k].
    - For k>0, captures neighbour k-1 into running min_r.
    - k=3 goes to LAST; otherwise k+1.
  - LAST: captures neighbour 3 into min_r. Goes to WR.
  - WR: res_wr=1, res_addr = centre, res_do = result. Advances the pixel; goes to RDC, or to FIN after the last pixel.
  - FIN: done=1 for one cycle, busy drops. Goes to IDLE.
- min_r is set to all-ones on entry to RDN k=0.
- Result arithmetic:
  - m1 = min_r + 1, saturating at 2^DW-1.
  - Forward result = m1.
  - Backward result = min(centre, m1).
  - Unsigned compares, DW bits.
- Cycle cost per pixel: zero pixel 2 cycles; non-zero pixel 8 cycles.
- Single-port memory rule: res_rd and res_wr are never high in the same cycle.
- res_addr, res_rd, res_wr and res_do are decoded from registered state only. There is no combinational path from res_di to any output.

Decomposition:
- dt_pkg holds:
  - W, H, DW, AW defaults.
  - Scan-state enum.
  - Direction encoding: DIR_FWD=0, DIR_BACK=1.
  - Neighbour offset constant array, indexed by dir and k.
  - Saturation max constant.
- One sub-module, dt_min_calc: combinational; inputs min_r, centre, dir; output res_do value. Kept separate so it can be reused by the backward-pass datapath.

Test Plan (W=H=8 unless stated; start asserted in cycle t):
- All-zero image, forward: 36 interior pixels × 2 cycles → zero res_wr; done pulses at t+74; busy high t+1..t+73.
- Single non-zero pixel (3,3)=255, rest 0, forward → exactly one write: addr 27, data 1, res_wr at the 8th cycle of that pixel.
- All-255 interior, 0 border, forward → (1,1) writes 1, (1,2) writes 1, (2,2) writes 2. Backward pass then leaves (6,6)=min(stored,1)=1.
- Neighbours all 255 (saturation), forward → res_do=255, no wrap to 0.
- Reset asserted in an RDN cycle mid-pass → next cycle all outputs 0, state IDLE; a new start restarts at addr 9 (forward) or 54 (backward).
- start pulsed while busy, plus a per-cycle assertion check → start ignored, done pulses exactly once; res_rd && res_wr never true in any cycle.

Source files
------------

// File: rtl/dt_pkg.sv
// Shared types and constants for the distance-transform scan sequencer.
package dt_pkg;

    // Default geometry and data widths.
    localparam int unsigned DtW  = 128;
    localparam int unsigned DtH  = 128;
    localparam int unsigned DtDw = 8;
    localparam int unsigned DtAw = 14;

    // Largest representable distance at the default width.
    localparam logic [DtDw-1:0] SatMax = '1;

    typedef enum logic [2:0] {
        StIdle,
        StRdc,
        StChk,
        StRdn,
        StLast,
        StWr,
        StFin
    } scan_state_e;

    typedef enum logic {
        DIR_FWD  = 1'b0,
        DIR_BACK = 1'b1
    } dir_e;

    // Neighbour offsets as {drow[1:0], dcol[1:0]}, two's complement, indexed [dir][k].
    // Forward  k0..k3: NW, N, NE, W.   Backward k0..k3: E, SW, S, SE.
    // Kept as row/col deltas so the table is independent of the image width.
    localparam logic [1:0][3:0][3:0] NbrOfs = {16'h5471, 16'h3DCF};

endpackage

// File: rtl/dt_scan_seq_if.sv
// Single-port res memory bus between the scan sequencer and the memory.
interface dt_scan_seq_if
    import dt_pkg::*;
#(
    parameter int unsigned AW = DtAw,
    parameter int unsigned DW = DtDw
);
    logic [AW-1:0] res_addr;
    logic          res_rd;
    logic          res_wr;
    logic [DW-1:0] res_do;
    logic [DW-1:0] res_di;

    modport master (
        output res_addr, res_rd, res_wr, res_do,
        input  res_di
    );

    modport slave (
        input  res_addr, res_rd, res_wr, res_do,
        output res_di
    );
endinterface

// File: rtl/dt_min_calc.sv
// Chamfer result: saturating min+1, clamped by the centre value on the backward pass.
module dt_min_calc
    import dt_pkg::*;
#(
    parameter int unsigned DW = DtDw
) (
    input  logic [DW-1:0] min_i,
    input  logic [DW-1:0] centre_i,
    input  dir_e          dir_i,
    output logic [DW-1:0] res_o
);
    logic [DW-1:0] m1;

    // Saturating increment followed by the direction-dependent clamp.
    always_comb begin
        m1 = (min_i == {DW{1'b1}}) ? min_i : min_i + DW'(1);
        res_o = m1;
        if (dir_i == DIR_BACK && centre_i < m1) begin
            res_o = centre_i;
        end
    end
endmodule

// File: rtl/dt_scan_seq.sv
// Pass sequencer: walks interior pixels, reads centre and four neighbours, writes result.
module dt_scan_seq
    import dt_pkg::*;
#(
    parameter int unsigned W  = DtW,
    parameter int unsigned H  = DtH,
    parameter int unsigned DW = DtDw,
    parameter int unsigned AW = DtAw
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic         dir_i,
    output logic         busy_o,
    output logic         done_o,
    dt_scan_seq_if.master res
);
    localparam int unsigned CW = $clog2(W);
    localparam int unsigned RW = AW - CW;

    localparam logic [CW-1:0] ColFirst = CW'(1);
    localparam logic [CW-1:0] ColLast  = CW'(W - 2);
    localparam logic [RW-1:0] RowFirst = RW'(1);
    localparam logic [RW-1:0] RowLast  = RW'(H - 2);

    scan_state_e   state_q, state_d;
    dir_e          dir_q, dir_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [1:0]    k_q, k_d;
    logic [DW-1:0] centre_q, centre_d;
    logic [DW-1:0] min_q, min_d;
    logic          done_q, done_d;

    logic [RW-1:0] adv_row, nbr_row;
    logic [CW-1:0] adv_col, nbr_col;
    logic          is_last;
    logic [3:0]    ofs;
    logic [DW-1:0] nbr_min;
    logic [DW-1:0] calc_res;

    dt_min_calc #(
        .DW(DW)
    ) u_min_calc (
        .min_i   (min_q),
        .centre_i(centre_q),
        .dir_i   (dir_q),
        .res_o   (calc_res)
    );

    // Next pixel position, last-pixel flag and current neighbour address.
    always_comb begin
        adv_row = row_q;
        adv_col = col_q;
        if (dir_q == DIR_FWD) begin
            is_last = (row_q == RowLast) && (col_q == ColLast);
            if (col_q == ColLast) begin
                adv_col = ColFirst;
                adv_row = row_q + RW'(1);
            end else begin
                adv_col = col_q + CW'(1);
            end
        end else begin
            is_last = (row_q == RowFirst) && (col_q == ColFirst);
            if (col_q == ColFirst) begin
                adv_col = ColLast;
                adv_row = row_q - RW'(1);
            end else begin
                adv_col = col_q - CW'(1);
            end
        end
        ofs     = NbrOfs[dir_q][k_q];
        nbr_row = row_q + {{(RW-2){ofs[3]}}, ofs[3:2]};
        nbr_col = col_q + {{(CW-2){ofs[1]}}, ofs[1:0]};
        nbr_min = (res.res_di < min_q) ? res.res_di : min_q;
    end

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            dir_q    <= DIR_FWD;
            row_q    <= '0;
            col_q    <= '0;
            k_q      <= '0;
            centre_q <= '0;
            min_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            row_q    <= row_d;
            col_q    <= col_d;
            k_q      <= k_d;
            centre_q <= centre_d;
            min_q    <= min_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        row_d    = row_q;
        col_d    = col_q;
        k_d      = k_q;
        centre_d = centre_q;
        min_d    = min_q;
        done_d   = (state_q == StFin);
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    dir_d   = dir_e'(dir_i);
                    row_d   = dir_i ? RowLast : RowFirst;
                    col_d   = dir_i ? ColLast : ColFirst;
                    state_d = StRdc;
                end
            end
            StRdc: state_d = StChk;
            StChk: begin
                centre_d = res.res_di;
                if (res.res_di == '0) begin
                    row_d   = adv_row;
                    col_d   = adv_col;
                    state_d = is_last ? StFin : StRdc;
                end else begin
                    k_d     = 2'd0;
                    min_d   = '1;
                    state_d = StRdn;
                end
            end
            StRdn: begin
                // Data for the read issued in the previous RDN cycle arrives now.
                if (k_q != 2'd0) begin
                    min_d = nbr_min;
                end
                if (k_q == 2'd3) begin
                    state_d = StLast;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            StLast: begin
                min_d   = nbr_min;
                state_d = StWr;
            end
            StWr: begin
                row_d   = adv_row;
                col_d   = adv_col;
                state_d = is_last ? StFin : StRdc;
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Memory strobes decoded from registered state only.
    always_comb begin
        res.res_addr = '0;
        res.res_rd   = 1'b0;
        res.res_wr   = 1'b0;
        res.res_do   = '0;
        case (state_q)
            StRdc: begin
                res.res_rd   = 1'b1;
                res.res_addr = {row_q, col_q};
            end
            StRdn: begin
                res.res_rd   = 1'b1;
                res.res_addr = {nbr_row, nbr_col};
            end
            StWr: begin
                // Suppress the write when reset lands on a WR cycle.
                res.res_wr   = reset;
                res.res_addr = {row_q, col_q};
                res.res_do   = calc_res;
            end
            default: ;
        endcase
        busy_o = (state_q != StIdle);
        done_o = done_q;
    end
endmodule

// File: tb/tb_dt_scan_seq.sv
// Directed bench for dt_scan_seq on an 8x8 image with a behavioural res memory.
module tb_dt_scan_seq;
    import dt_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned H  = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 6;

    logic clk     = 1'b0;
    logic reset   = 1'b0;
    logic start_i = 1'b0;
    logic dir_i   = 1'b0;
    logic busy_o;
    logic done_o;

    dt_scan_seq_if #(.AW(AW), .DW(DW)) bus ();

    dt_scan_seq #(
        .W (W),
        .H (H),
        .DW(DW),
        .AW(AW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start_i(start_i),
        .dir_i  (dir_i),
        .busy_o (busy_o),
        .done_o (done_o),
        .res    (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port memory with one-cycle read latency and fill port.
    logic [DW-1:0] mem [W*H];
    logic          fill_go   = 1'b0;
    int            fill_mode = 0;
    always @(posedge clk) begin
        if (fill_go) begin
            for (int a = 0; a < W*H; a++) begin
                if (fill_mode == 0) begin
                    mem[a] <= 8'd0;
                end else if (fill_mode == 2) begin
                    mem[a] <= 8'd255;
                end else begin
                    mem[a] <= ((a / W) == 0 || (a / W) == H-1 || (a % W) == 0 ||
                               (a % W) == W-1) ? 8'd0 : 8'd255;
                end
            end
        end else if (bus.res_wr) begin
            mem[bus.res_addr] <= bus.res_do;
        end
        if (bus.res_rd) bus.res_di <= mem[bus.res_addr];
    end

    // Cumulative observation log, sampled mid-cycle.
    int done_cnt = 0, done_cyc = 0, busy_cnt = 0, busy_last = 0, collisions = 0;
    int wr_a[$], wr_d[$], wr_c[$];
    always @(negedge clk) begin
        if (bus.res_rd && bus.res_wr) collisions++;
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy_o) begin
            busy_cnt++;
            busy_last = cyc;
        end
        if (bus.res_wr) begin
            wr_a.push_back(int'(bus.res_addr));
            wr_d.push_back(int'(bus.res_do));
            wr_c.push_back(cyc);
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill_mem(input int m);
        @(posedge clk); #1;
        fill_mode = m;
        fill_go   = 1'b1;
        @(posedge clk); #1;
        fill_go   = 1'b0;
    endtask

    // Pulses start for one cycle; t is the cycle in which start is high.
    task automatic start_pass(input logic d, output int t);
        @(posedge clk); #1;
        start_i = 1'b1;
        dir_i   = d;
        t       = cyc;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base, input int budget);
        int n = 0;
        while (done_cnt == base && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, done_cnt - base, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, int'(busy_o), 0);
        check_eq({tag, "_done"}, int'(done_o), 0);
        check_eq({tag, "_rd"},   int'(bus.res_rd), 0);
        check_eq({tag, "_wr"},   int'(bus.res_wr), 0);
        check_eq({tag, "_addr"}, int'(bus.res_addr), 0);
        check_eq({tag, "_do"},   int'(bus.res_do), 0);
    endtask

    initial begin
        int t, db, bb, wb;

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset = 1'b1;

        // All-zero image, forward: no writes, 74-cycle pass.
        fill_mem(0);
        db = done_cnt; bb = busy_cnt; wb = wr_a.size();
        start_pass(1'b0, t);
        wait_done("zero_done_seen", db, 200);
        check_eq("zero_writes", wr_a.size() - wb, 0);
        check_eq("zero_done_cyc", done_cyc - t, 74);
        check_eq("zero_busy_cycles", busy_cnt - bb, 73);
        check_eq("zero_busy_last", busy_last - t, 73);

        // Single non-zero pixel at (3,3).
        fill_mem(0);
        @(posedge clk); #1;
        mem[27] = 8'd255;
        db = done_cnt; wb = wr_a.size();
        start_pass(1'b0, t);
        wait_done("single_done_seen", db, 200);
        check_eq("single_writes", wr_a.size() - wb, 1);
        if (wr_a.size() > wb) begin
            check_eq("single_addr", wr_a[wb], 27);
            check_eq("single_data", wr_d[wb], 1);
            check_eq("single_wr_cyc", wr_c[wb] - t, 36);
        end
        check_eq("single_done_cyc", done_cyc - t, 80);

        // Interior 255, border 0: forward then backward.
        fill_mem(1);
        db = done_cnt; wb = wr_a.size();
        start_pass(1'b0, t);
        wait_done("fwd_done_seen", db, 600);
        check_eq("fwd_writes", wr_a.size() - wb, 36);
        check_eq("fwd_mem9", int'(mem[9]), 1);
        check_eq("fwd_mem10", int'(mem[10]), 1);
        check_eq("fwd_mem18", int'(mem[18]), 2);
        db = done_cnt; wb = wr_a.size();
        start_pass(1'b1, t);
        wait_done("bwd_done_seen", db, 600);
        if (wr_a.size() > wb) begin
            check_eq("bwd_first_addr", wr_a[wb], 54);
            check_eq("bwd_first_data", wr_d[wb], 1);
        end
        check_eq("bwd_mem54", int'(mem[54]), 1);

        // Saturation: every neighbour 255.
        fill_mem(2);
        db = done_cnt; wb = wr_a.size();
        start_pass(1'b0, t);
        wait_done("sat_done_seen", db, 600);
        if (wr_a.size() > wb) begin
            check_eq("sat_first_addr", wr_a[wb], 9);
            check_eq("sat_first_data", wr_d[wb], 255);
        end
        check_eq("sat_mem54", int'(mem[54]), 255);

        // Reset in RDN k=1 of the first pixel, then restart both directions.
        fill_mem(2);
        start_pass(1'b0, t);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check_eq("rdn_cycle", cyc - t, 4);
        check_eq("rdn_rd", int'(bus.res_rd), 1);
        check_eq("rdn_n_addr", int'(bus.res_addr), 1);
        reset = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("midreset");
        reset = 1'b1;
        db = done_cnt;
        start_pass(1'b0, t);
        check_eq("restart_fwd_rd", int'(bus.res_rd), 1);
        check_eq("restart_fwd_addr", int'(bus.res_addr), 9);
        wait_done("restart_fwd_done", db, 600);
        db = done_cnt;
        start_pass(1'b1, t);
        check_eq("restart_bwd_rd", int'(bus.res_rd), 1);
        check_eq("restart_bwd_addr", int'(bus.res_addr), 54);
        wait_done("restart_bwd_done", db, 600);

        // start while busy is ignored.
        fill_mem(0);
        db = done_cnt; wb = wr_a.size();
        start_pass(1'b0, t);
        repeat (8) @(posedge clk);
        #1;
        start_i = 1'b1;
        dir_i   = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        dir_i   = 1'b0;
        wait_done("busy_start_done", db, 200);
        repeat (20) @(negedge clk);
        check_eq("busy_start_done_once", done_cnt - db, 1);
        check_eq("busy_start_done_cyc", done_cyc - t, 74);
        check_eq("busy_start_writes", wr_a.size() - wb, 0);

        check_eq("rd_wr_collisions", collisions, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
